led_pattern_engine: RTL and testbench
=====================================

// Module: led_pattern_engine
// PURPOSE
//  Parametrised LED pattern generator for the board LED banks (LEDR/LEDG).
//  Generalises the fixed alternating blinker: selectable step period,
//  four pattern modes, configurable LED count, pause/enable control and a
//  step-tick output. Sits between the board switches and the LED pins;
//  clocked from CLOCK_50.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  N_LEDS   18          number of LED outputs driven (>=2)
//  CNT_W    28          prescaler width; must hold (CLK_HZ*2)-1
// PORTS
//  CLOCK_50   in   1       system clock, rising edge
//  reset      in   1       asynchronous reset, active-high
//  enable     in   1       1 = run; 0 = LEDs dark, engine held at start
//  pause      in   1       1 = freeze prescaler and pattern (LEDs hold)
//  speed_sel  in   2       step period: 0=0.25s 1=0.5s 2=1s 3=2s
//  mode       in   2       0=ALT 1=CHASE 2=BOUNCE 3=BLINK
//  leds       out  N_LEDS  LED drive, 1 = lit
//  step_tick  out  1       1-cycle pulse on every pattern step
// BEHAVIOUR
//  Reset: prescaler=0, pattern=start(ALT)={..0101} (bit0=1), dir=up,
//   leds=0, step_tick=0, stored mode/speed = ALT/0.
//  Period: PERIOD = (CLK_HZ/4) << speed_sel cycles; prescaler counts
//   0..PERIOD-1; step_tick asserts in the cycle count==PERIOD-1, count->0.
//   Comparison is >=, so a count above the limit (after a speed change)
//   can never run away; speed_sel change clears prescaler next cycle,
//   no tick in that cycle.
//  Pattern start states: ALT {..0101}; CHASE/BOUNCE one-hot bit0, dir=up;
//   BLINK all ones.
//  Step rules (on step_tick, pattern registered, updates next cycle):
//   ALT    pattern <= ~pattern
//   CHASE  rotate left, bit N_LEDS-1 wraps to bit0
//   BOUNCE shift by dir; reaching bit N_LEDS-1 sets dir=down, reaching
//          bit0 sets dir=up; endpoints lit for exactly one step each
//   BLINK  pattern <= ~pattern (all on / all off)
//  Mode change: detected by registered copy; next cycle pattern loads the
//   new mode's start state, prescaler clears, no tick that cycle.
//   Mode change and tick in same cycle: mode change wins.
//  enable=0: leds=0, prescaler held 0, pattern held at current mode start,
//   step_tick=0. On enable 0->1 first step occurs PERIOD cycles later.
//  pause=1 (enable=1): prescaler and pattern frozen, leds show pattern,
//   step_tick=0; resume continues from frozen count. enable=0 overrides
//   pause. Mode/speed changes during pause still reset as above.
//  leds = enable ? pattern : 0 (registered, 1-cycle after pattern).
//  reset asserted mid-run: all state to reset values immediately.
// STRUCTURE
//  Package led_pattern_pkg: mode constants (MODE_ALT/CHASE/BOUNCE/BLINK),
//   speed codes, function period_cycles(clk_hz, sel).
//  Sub-module led_tick_gen: prescaler + speed-change clear -> step_tick.
//  Top holds pattern register, dir bit, mode-change detect, output gate.
// TESTING (bench uses CLK_HZ=8 -> periods 2/4/8/16 cycles, N_LEDS=4)
//  1 reset, enable=1 mode=ALT sel=0 -> leds 0101,1010,0101 every 2 cycles;
//    step_tick once per 2 cycles.
//  2 mode=CHASE sel=1 -> 0001,0010,0100,1000,0001 every 4 cycles (wrap).
//  3 mode=BOUNCE sel=0 -> 0001,0010,0100,1000,0100,0010,0001,0010.
//  4 sel 3->0 while count=10 -> count cleared, next tick after 2 cycles,
//    never a missed/stuck period.
//  5 pause=1 for 20 cycles mid-CHASE -> leds constant, no step_tick;
//    release -> remaining count completes then steps.
//  6 enable=0 -> leds=0000 next cycle; mode=BLINK, enable=1 -> 1111 until
//    first tick, then 0000; reset pulse mid-run -> leds=0, ALT start.

Source files
------------

// File: rtl/led_pattern_engine_pkg.sv
// Shared constants and helpers for the LED pattern engine: mode/speed codes,
// bounce direction and the step-period calculation.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ALT    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SPEED_QUARTER = 2'd0,
        SPEED_HALF    = 2'd1,
        SPEED_ONE     = 2'd2,
        SPEED_TWO     = 2'd3
    } speed_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Step period in clock cycles: a quarter second doubled per speed code.
    function automatic logic [31:0] period_cycles(input int unsigned clk_hz, input logic [1:0] sel);
        return (32'(clk_hz) / 32'd4) << sel;
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between the board switches and the LED pattern engine.
interface led_pattern_engine_if #(
    parameter int N_LEDS = 18
);
    logic              enable;
    logic              pause;
    logic [1:0]        speed_sel;
    logic [1:0]        mode;
    logic [N_LEDS-1:0] leds;
    logic              step_tick;

    modport master (
        output enable, pause, speed_sel, mode,
        input  leds, step_tick
    );

    modport slave (
        input  enable, pause, speed_sel, mode,
        output leds, step_tick
    );
endinterface

// File: rtl/led_pattern_engine_tick_gen.sv
// Prescaler producing a one-cycle step tick every selected period; a speed
// change or an external clear restarts the count without ticking.
module led_tick_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pause,
    input  logic       clear,
    input  logic [1:0] speed_sel,
    output logic       tick
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] limit;
    logic [1:0]       sel_reg;
    logic             sel_chg;
    logic             at_limit;

    assign limit    = CNT_W'(period_cycles(CLK_HZ, speed_sel) - 32'd1);
    assign sel_chg  = (speed_sel != sel_reg);
    // >= so a count left above a shorter limit still terminates the period
    assign at_limit = (count_reg >= limit);
    assign tick     = enable & ~pause & ~sel_chg & ~clear & at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            sel_reg   <= 2'd0;
        end else begin
            sel_reg <= speed_sel;
            if (!enable || sel_chg || clear || tick) begin
                count_reg <= '0;
            end else if (!pause) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: pattern register, bounce direction, mode-change
// detection and the registered enable gate on the LED outputs.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int N_LEDS = 18,
    parameter int CNT_W  = 28
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    led_pattern_engine_if.slave  bus
);

    logic [N_LEDS-1:0] pattern_reg;
    logic [N_LEDS-1:0] pattern_next;
    logic [N_LEDS-1:0] leds_reg;
    logic [N_LEDS-1:0] alt_start;
    logic [N_LEDS-1:0] start_pat;
    dir_e              dir_reg;
    dir_e              dir_next;
    mode_e             mode_reg;
    logic              mode_chg;
    logic              tick;

    // Alternating start pattern ..0101 with bit0 lit
    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_alt
            assign alt_start[gi] = ((gi % 2) == 0);
        end
    endgenerate

    assign mode_chg = (mode_e'(bus.mode) != mode_reg);

    led_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_tick_gen (
        .clk       (CLOCK_50),
        .rst       (reset),
        .enable    (bus.enable),
        .pause     (bus.pause),
        .clear     (mode_chg),
        .speed_sel (bus.speed_sel),
        .tick      (tick)
    );

    always_comb begin
        start_pat = alt_start;
        case (mode_e'(bus.mode))
            MODE_ALT:    start_pat = alt_start;
            MODE_CHASE,
            MODE_BOUNCE: start_pat = {{(N_LEDS-1){1'b0}}, 1'b1};
            MODE_BLINK:  start_pat = '1;
            default:     start_pat = alt_start;
        endcase
    end

    always_comb begin
        pattern_next = pattern_reg;
        dir_next     = dir_reg;
        case (mode_reg)
            MODE_ALT,
            MODE_BLINK:  pattern_next = ~pattern_reg;
            MODE_CHASE:  pattern_next = {pattern_reg[N_LEDS-2:0], pattern_reg[N_LEDS-1]};
            MODE_BOUNCE: begin
                // Direction flips on the step that lands on an endpoint
                if (dir_reg == DIR_UP) begin
                    pattern_next = pattern_reg << 1;
                    dir_next     = pattern_next[N_LEDS-1] ? DIR_DOWN : DIR_UP;
                end else begin
                    pattern_next = pattern_reg >> 1;
                    dir_next     = pattern_next[0] ? DIR_UP : DIR_DOWN;
                end
            end
            default: pattern_next = pattern_reg;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pattern_reg <= alt_start;
            dir_reg     <= DIR_UP;
            mode_reg    <= MODE_ALT;
            leds_reg    <= '0;
        end else begin
            mode_reg <= mode_e'(bus.mode);
            leds_reg <= bus.enable ? pattern_reg : '0;
            if (!bus.enable || mode_chg) begin
                pattern_reg <= start_pat;
                dir_reg     <= DIR_UP;
            end else if (tick) begin
                pattern_reg <= pattern_next;
                dir_reg     <= dir_next;
            end
        end
    end

    assign bus.leds      = leds_reg;
    assign bus.step_tick = tick;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed scenarios then random control
// changes, compared cycle by cycle against a step-count reference model.
module tb_led_pattern_engine;

    localparam int CLK_HZ = 8;
    localparam int N      = 4;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic reset;

    led_pattern_engine_if #(.N_LEDS(N)) bus ();

    led_pattern_engine #(
        .CLK_HZ (CLK_HZ),
        .N_LEDS (N),
        .CNT_W  (CNT_W)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // Reference model: pattern described by mode and number of steps taken
    int           m_mode;
    int           m_sel;
    int           m_cnt;
    int           m_steps;
    logic [N-1:0] m_leds;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period(input int sel);
        return (CLK_HZ / 4) << sel;
    endfunction

    function automatic logic [N-1:0] model_pat(input int md, input int s);
        logic [N-1:0] one;
        logic [N-1:0] alt;
        int k;
        int p;
        one = 1;
        alt = '0;
        for (int i = 0; i < N; i += 2) alt[i] = 1'b1;
        case (md)
            0: return (s % 2 == 0) ? alt : ~alt;
            1: return one << (s % N);
            2: begin
                k = s % (2 * N - 2);
                p = (k < N) ? k : (2 * N - 2 - k);
                return one << p;
            end
            default: return (s % 2 == 0) ? '1 : '0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_sel   = 0;
        m_cnt   = 0;
        m_steps = 0;
        m_leds  = '0;
    endtask

    task automatic drive_cycle(input logic en, input logic pa, input int sel, input int mo);
        logic mode_chg;
        logic sel_chg;
        logic tk;
        bus.enable    = en;
        bus.pause     = pa;
        bus.speed_sel = 2'(sel);
        bus.mode      = 2'(mo);
        #2;
        mode_chg = (mo != m_mode);
        sel_chg  = (sel != m_sel);
        tk = en && !pa && !mode_chg && !sel_chg && (m_cnt == period(sel) - 1);
        check("step_tick", 32'(bus.step_tick), 32'(tk));
        @(posedge clk);
        #1;
        m_leds = en ? model_pat(m_mode, m_steps) : '0;
        if (!en || mode_chg) m_steps = 0;
        else if (tk) m_steps++;
        if (!en || mode_chg || sel_chg || tk) m_cnt = 0;
        else if (!pa) m_cnt++;
        m_mode = mo;
        m_sel  = sel;
        check("leds", 32'(bus.leds), 32'(m_leds));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_leds", 32'(bus.leds), 32'(0));
        check("rst_tick", 32'(bus.step_tick), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic r_en;
    logic r_pa;
    int   r_sel;
    int   r_mo;

    initial begin
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.pause     = 1'b0;
        bus.speed_sel = 2'd0;
        bus.mode      = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_leds", 32'(bus.leds), 32'(0));
        check("reset_tick", 32'(bus.step_tick), 32'(0));
        reset = 1'b0;

        // ALT at the fastest speed
        drive_cycle(1, 0, 0, 0);
        check("alt_first", 32'(bus.leds), 32'(4'b0101));
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 0, 0, 0);
        check("alt_second", 32'(bus.leds), 32'(4'b1010));
        repeat (5) drive_cycle(1, 0, 0, 0);

        // CHASE with wrap, then BOUNCE through both endpoints
        repeat (20) drive_cycle(1, 0, 1, 1);
        repeat (20) drive_cycle(1, 0, 0, 2);

        // Slowest speed, then drop to fastest mid-period
        repeat (12) drive_cycle(1, 0, 3, 1);
        repeat (6) drive_cycle(1, 0, 0, 1);

        // Pause mid-CHASE and resume
        repeat (6) drive_cycle(1, 0, 1, 1);
        repeat (20) drive_cycle(1, 1, 1, 1);
        repeat (10) drive_cycle(1, 0, 1, 1);

        // Disable, BLINK from enable, asynchronous reset mid-run
        repeat (3) drive_cycle(0, 0, 1, 1);
        drive_cycle(0, 0, 0, 3);
        repeat (6) drive_cycle(1, 0, 0, 3);
        pulse_reset();
        repeat (4) drive_cycle(1, 0, 0, 0);

        // Random control changes
        r_en  = 1'b1;
        r_pa  = 1'b0;
        r_sel = 0;
        r_mo  = 0;
        for (int i = 0; i < 900; i++) begin
            if (r_en ? ($urandom_range(99) < 3) : ($urandom_range(99) < 20)) r_en = ~r_en;
            if (r_pa ? ($urandom_range(99) < 15) : ($urandom_range(99) < 4)) r_pa = ~r_pa;
            if ($urandom_range(99) < 3) r_sel = $urandom_range(3);
            if ($urandom_range(99) < 3) r_mo = $urandom_range(3);
            if ($urandom_range(299) == 0) pulse_reset();
            drive_cycle(r_en, r_pa, r_sel, r_mo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
